ram_block_reader: RTL
=====================

# ram_block_reader

Streaming read client for the team's single-port synchronous RAM, whose `read_data` is the word at the `address` presented one cycle earlier. On `start`, fetches `length` consecutive words beginning at `start_address`, wrapping modulo `DEPTH`, and presents them in order on a valid/ready output stream. Internal buffering absorbs the RAM's one-cycle read latency, so downstream back-pressure never drops or duplicates a word. Sits between a RAM instance (write port owned elsewhere, read side driven here) and any stream consumer such as a display or serial TX.

## Interface
- `SIZE`, default 8: word width; must match the RAM's `SIZE`.
- `DEPTH`, default 256: RAM entry count; `AW = $clog2(DEPTH)`; need not be a power of two.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a transfer; sampled only while `busy`=0.
- `start_address` in AW: first RAM address; sampled with `start`.
- `length` in AW+1: words to read, 0..DEPTH; sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at end of transfer.
- `ram_address` out AW: RAM address, driven from a register.
- `ram_read_data` in SIZE: RAM `read_data`.
- `out_data` out SIZE: stream word.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts the word when `out_valid`=1 and `out_ready`=1.

## Operation
- Reset values: `busy`=0, `done`=0, `ram_address`=0, `out_valid`=0, `out_data`=0. Buffer, counters, and in-flight flag are cleared; state is IDLE.
- States:
  - **IDLE**: `start`=1 with `length`>0 latches the request and moves to READ. `start`=1 with `length`=0 moves to FINISH.
  - **READ**: issues reads. When the last read has been issued, moves to DRAIN.
  - **DRAIN**: waits until every issued word has been accepted, then moves to FINISH.
  - **FINISH**: lasts one cycle, pulses `done`=1, then returns to IDLE.
- `busy`=1 in every state other than IDLE. `start` while `busy`=1 is ignored and does not change the latched request.
- Issue rule: a read is issued in a cycle when the state is READ, words remain to issue, and (buffer count + in-flight − pop this cycle) < 2.
  - "Pop" means `out_valid`=1 and `out_ready`=1 in that cycle.
  - On issue, the RAM samples the current `ram_address`. `ram_address` then advances, wrapping from DEPTH−1 to 0, and the in-flight flag is set.
- The word arriving on `ram_read_data` in the cycle after an issue is pushed into a 2-entry FIFO. The buffer can never overflow.
- `out_data` and `out_valid` are driven from the FIFO head, which is registered. `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
- Words are delivered in address order, exactly `length` of them, with no gaps, repeats, or drops.
- Counters are AW+1 bits wide, so `length`=DEPTH is legal and reads every entry exactly once.
- Asserting `rst_n` low mid-transfer aborts the transfer immediately. Outputs return to reset values, no `done` pulse is produced, and any buffered words are discarded.

## Timing
- Cycle 0: `start` is accepted (IDLE, `length`>0).
- Cycle 1: `busy`=1 and `ram_address`=`start_address`. The first read issues in this cycle.
- Cycle 3: first `out_valid`=1. Latency from start to first word is 3 cycles.
- With `out_ready` held at 1, throughput is one word per cycle.
- `done` pulses in the cycle after the last word is accepted. `busy` falls in the following cycle, at which point a new `start` can be accepted.
- Minimum transfer: with `length`=N and `out_ready`=1 throughout, `done` is high in cycle N+3.
- With `length`=0, `done` is high in cycle 1.
- No combinational path from any input to `out_valid` or `out_data`. `out_ready` may combinationally affect only the next-state logic.

## Test plan
- RAM preloaded with value = address. `start_address`=10, `length`=4, `out_ready`=1 → `out_data` 10,11,12,13 on cycles 3–6; `done` high in cycle 7; `busy` low in cycle 8.
- Same transfer with `out_ready` toggling 1,0,0,1,… → the same 4 words in order, each held stable while stalled, none lost or duplicated; `done` in the cycle after the 4th accept.
- DEPTH=256, `start_address`=254, `length`=4 → output 254,255,0,1.
- DEPTH=10 (not a power of two), `start_address`=8, `length`=10 → output 8,9,0..7.
- `length`=0 → no `out_valid`; `done` high in cycle 1. Then `length`=256 from address 0 → all 256 words, `done` once.
- `start` pulsed again mid-transfer → ignored. `rst_n` driven low after the 2nd word → all outputs 0 immediately and no `done`; a fresh `start` after release works normally.

Source files
------------

// File: rtl/ram_block_reader.sv
// ram_block_reader: streams `length` consecutive RAM words from `start_address` onto a valid/ready port
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              request a transfer; only honoured while busy = 0
//   start_address      first RAM address, sampled with start
//   length             number of words (0..DEPTH), sampled with start
//   busy               transfer in progress
//   done               one-cycle pulse when the transfer completes
//   ram_address        registered read address to the RAM
//   ram_read_data      RAM read data, valid one cycle after the address was sampled
//   out_data           stream word, held stable while stalled
//   out_valid          out_data is valid
//   out_ready          consumer accepts the word when out_valid = 1
module ram_block_reader #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   start_address,
    input  logic [AW:0]     length,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   ram_address,
    input  logic [SIZE-1:0] ram_read_data,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t         state;
    logic [AW:0]    left;
    logic [1:0]     count;
    logic           in_flight;
    logic [SIZE-1:0] tail;
    logic           pop;
    logic [1:0]     kept;
    logic [1:0]     occ;
    logic           issue;

    // out_data is the FIFO head; tail holds the second entry.
    // occ is the occupancy after this cycle's pop and the pending push,
    // which is also next cycle's buffer count.
    assign pop   = out_valid & out_ready;
    assign kept  = count - {1'b0, pop};
    assign occ   = kept + {1'b0, in_flight};
    assign issue = (state == READ) && (left != '0) && (occ < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            left        <= '0;
            count       <= '0;
            in_flight   <= 1'b0;
            tail        <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            count     <= occ;
            out_valid <= occ != 2'd0;
            in_flight <= issue;
            if (in_flight) begin
                if (kept == 2'd0)
                    out_data <= ram_read_data;
                else
                    tail <= ram_read_data;
            end
            if (pop && count == 2'd2)
                out_data <= tail;
            if (issue) begin
                ram_address <= (ram_address == AW'(DEPTH - 1)) ? '0 : ram_address + 1'b1;
                left        <= left - 1'b1;
            end
            unique case (state)
                IDLE: if (start) begin
                    ram_address <= start_address;
                    left        <= length;
                    state       <= (length != '0) ? READ : FINISH;
                    busy        <= 1'b1;
                    done        <= length == '0;
                end
                READ: if (issue && left == (AW+1)'(1)) state <= DRAIN;
                DRAIN: if (occ == 2'd0) begin
                    state <= FINISH;
                    done  <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
